// File: rtl/rv_defines.sv
// Shared definitions for the open_risc_v front end: widths, reset PC and the
// fetch-buffer entry layout used between the prefetcher and its FIFO.
package rv_defines;

    localparam int          RV_XLEN     = 32;
    localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;
    // Canonical NOP (addi x0, x0, 0), kept for future bubble insertion.
    localparam logic [31:0] RV_INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [RV_XLEN-1:0] pc;
        logic [RV_XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [RV_XLEN-1:0] rv_word_align(input logic [RV_XLEN-1:0] addr);
        return {addr[RV_XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous power-of-two FIFO with a synchronous flush. Callers must respect
// full/empty themselves; overflow and underflow are only flagged by assertions.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_push && !i_pop)      r_count <= r_count + 1'b1;
            else if (!i_push && i_pop) r_count <= r_count - 1'b1;
        end
    end

    // Storage carries no reset; only the pointers decide what is visible.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end

    always @(posedge clk) begin
        if (rst_n && !i_flush) begin
            assert (!(i_push && !i_pop && (r_count == CW'(DEPTH))));
            assert (!(i_pop && (r_count == '0)));
        end
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetcher: issues sequential word reads to a 1-cycle ROM, buffers
// {pc, inst} pairs and hands them to decode; a jump flushes and redirects.
module inst_prefetch
    import rv_defines::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RV_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ready_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_issued_pc;
    logic          r_inflight;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_occupancy;
    logic          w_req;
    logic          w_push;
    logic          w_pop;
    logic          w_valid;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head_entry;
    logic [$bits(fetch_entry_t)-1:0] w_head_data;

    // Occupancy counts the outstanding read so a response always has a slot.
    assign w_occupancy = {1'b0, w_count} + (CW+1)'(r_inflight);
    assign w_req       = rst_n && !jump_en_i && (w_occupancy < (CW+1)'(DEPTH));
    assign w_push      = r_inflight && !jump_en_i;
    assign w_valid     = (w_count != '0);
    assign w_pop       = w_valid && inst_ready_i && !jump_en_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc  <= rv_word_align(RESET_PC);
            r_issued_pc <= '0;
            r_inflight  <= 1'b0;
        end else if (jump_en_i) begin
            r_fetch_pc <= rv_word_align(jump_addr_i);
            r_inflight <= 1'b0;
        end else if (w_req) begin
            r_fetch_pc  <= r_fetch_pc + 32'd4;
            r_issued_pc <= r_fetch_pc;
            r_inflight  <= 1'b1;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    assign w_push_entry.pc   = r_issued_pc;
    assign w_push_entry.inst = rom_inst_i;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fetch_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (jump_en_i),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head_data (w_head_data),
        .o_count     (w_count)
    );

    assign w_head_entry = w_head_data;

    assign rom_req_o    = w_req;
    assign rom_addr_o   = r_fetch_pc;
    assign inst_valid_o = w_valid;
    assign inst_o       = w_valid ? w_head_entry.inst : 32'h0;
    assign inst_addr_o  = w_valid ? w_head_entry.pc   : 32'h0;

endmodule
